ctl_unit_lfield_n: RTL and testbench
====================================

CTL_UNIT_LFIELD_N -- requirements
Module: ctl_unit_lfield_n

Interface
REQ-001 Parameter N_BYTES, 2: number of length-field bytes received per frame (1..4).
REQ-002 Parameter BYTE_W, 8: width of each received byte.
REQ-003 Parameter MIN_LEN, 1: smallest accepted length value.
REQ-004 Parameter MAX_LEN, 64: largest accepted length value.
REQ-005 Parameter TIMEOUT_CYC, 1000: maximum idle cycles between bytes; 0 disables the timeout.
REQ-006 clk  input  1  single clock for all logic; one clock, all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 VALIDSTART  input  1  starts a length-field capture; honoured only in IDLE.
REQ-009 RXINT  input  1  receiver byte-ready indication.
REQ-010 RXDATA  input  BYTE_W  received byte; valid in any cycle where RXINT=1.
REQ-011 UNLOCKME  input  1  releases LOCKED or ERROR; ignored in all other states.
REQ-012 CLEARFLAG  output  1  one-cycle strobe that clears the receiver interrupt.
REQ-013 INITFLAG  output  N_BYTES  one-hot strobe; bit k high for one cycle when byte k is loaded.
REQ-014 LENGTH  output  N_BYTES*BYTE_W  assembled length, first received byte most significant.
REQ-015 VALIDLENGTHFLAG  output  1  one-cycle strobe: LENGTH is in range.
REQ-016 ERRFLAG  output  1  level: range or timeout error, held until UNLOCKME.
REQ-017 LOCKEDFLAG  output  1  level: LENGTH valid and frozen.
REQ-018 UNLOCKPASTFLAG  output  1  level: block is in IDLE.

Function
REQ-019 States SHALL be IDLE, WAITB, CLEARI, INIT, CHECK, ISVALID, LOCKED, ERROR; all outputs are Moore-decoded from state, except LENGTH, which is registered.
REQ-020 IDLE: VALIDSTART=1 -> WAITB; on that transition LENGTH clears to 0 and byte index clears to 0.
REQ-021 WAITB: RXINT=1 -> CLEARI, capturing RXDATA into a byte holding register; the timeout counter runs from 0 on WAITB entry.
REQ-022 WAITB: when the counter reaches TIMEOUT_CYC (TIMEOUT_CYC>0) with RXINT=0 -> ERROR; if RXINT=1 in that same cycle, RXINT wins and the next state is CLEARI.
REQ-023 CLEARI: CLEARFLAG=1 for exactly one cycle -> INIT unconditionally.
REQ-024 INIT: INITFLAG[index]=1 for one cycle and LENGTH <= {LENGTH[N_BYTES*BYTE_W-BYTE_W-1:0], held byte}; index=N_BYTES-1 -> CHECK, otherwise index increments and the next state is WAITB.
REQ-025 CHECK: MIN_LEN <= LENGTH <= MAX_LEN (unsigned) -> ISVALID; otherwise -> ERROR.
REQ-026 ISVALID: VALIDLENGTHFLAG=1 for one cycle -> LOCKED.
REQ-027 LOCKED: LOCKEDFLAG=1 and LENGTH held; UNLOCKME=1 -> IDLE.
REQ-028 ERROR: ERRFLAG=1 and LENGTH held for debug; UNLOCKME=1 -> IDLE.
REQ-029 Latency: RXINT of the last byte seen in cycle t -> CLEARFLAG at t+1, INITFLAG at t+2, VALIDLENGTHFLAG or ERRFLAG first high at t+4.
REQ-030 RXINT SHALL be ignored outside WAITB; UNLOCKME and VALIDSTART SHALL be ignored outside their listed states.
REQ-031 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-032 reset=1 at a clock edge SHALL force IDLE, LENGTH=0, byte index=0, timeout counter=0, and the holding register=0, from any state including mid-frame.
REQ-033 Outputs after reset SHALL be UNLOCKPASTFLAG=1 and all other outputs 0.
REQ-034 reset SHALL take priority over every other input in the same cycle.

Verification (N_BYTES=2, BYTE_W=8, MIN_LEN=1, MAX_LEN=64, TIMEOUT_CYC=100)
REQ-035 VALIDSTART, then RXINT with 0x00, then RXINT with 0x20 -> INITFLAG pulses 01 then 10, LENGTH=0x0020, one VALIDLENGTHFLAG pulse, LOCKEDFLAG=1 until UNLOCKME, then UNLOCKPASTFLAG=1.
REQ-036 Bytes 0x01, 0x00 (256) -> ERRFLAG=1, LENGTH=0x0100, VALIDLENGTHFLAG never asserted; bytes 0x00, 0x00 -> ERRFLAG=1.
REQ-037 After the first byte, RXINT held low -> ERRFLAG rises on the 101st cycle after WAITB entry; with RXINT=1 in the counter-equals-100 cycle, the byte is accepted and there is no error.
REQ-038 Assert reset while in WAITB for byte 2 -> next cycle is IDLE, LENGTH=0, UNLOCKPASTFLAG=1; a subsequent full frame with 0x00, 0x05 locks with LENGTH=0x0005.
REQ-039 Apply RXINT pulses while LOCKED, and UNLOCKME while in WAITB -> no state change, no CLEARFLAG, LENGTH unchanged.
REQ-040 A bench with N_BYTES=3, bytes 0x00, 0x00, 0x40, and MAX_LEN=64 -> LENGTH=0x000040 and VALIDLENGTHFLAG pulses.

Source files
------------

// File: rtl/ctl_unit_lfield_n_if.sv
// Length-field capture bus: receiver/control inputs toward the capture unit
// and its strobes, levels and assembled length back to the consumer.
interface ctl_unit_lfield_n_if #(
  parameter int unsigned N_BYTES = 2,
  parameter int unsigned BYTE_W  = 8
);
  logic                        VALIDSTART;
  logic                        RXINT;
  logic [BYTE_W-1:0]           RXDATA;
  logic                        UNLOCKME;
  logic                        CLEARFLAG;
  logic [N_BYTES-1:0]          INITFLAG;
  logic [N_BYTES*BYTE_W-1:0]   LENGTH;
  logic                        VALIDLENGTHFLAG;
  logic                        ERRFLAG;
  logic                        LOCKEDFLAG;
  logic                        UNLOCKPASTFLAG;

  modport master (
    output VALIDSTART, RXINT, RXDATA, UNLOCKME,
    input  CLEARFLAG, INITFLAG, LENGTH, VALIDLENGTHFLAG, ERRFLAG,
           LOCKEDFLAG, UNLOCKPASTFLAG
  );

  modport slave (
    input  VALIDSTART, RXINT, RXDATA, UNLOCKME,
    output CLEARFLAG, INITFLAG, LENGTH, VALIDLENGTHFLAG, ERRFLAG,
           LOCKEDFLAG, UNLOCKPASTFLAG
  );
endinterface

// File: rtl/ctl_unit_lfield_n.sv
// Length-field capture controller: collects N_BYTES receiver bytes (first
// byte most significant), range-checks the assembled length and then locks
// it (or flags an error) until released. A per-byte idle timeout guards the
// gap between bytes.
module ctl_unit_lfield_n #(
  parameter int unsigned N_BYTES     = 2,
  parameter int unsigned BYTE_W      = 8,
  parameter int unsigned MIN_LEN     = 1,
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  ctl_unit_lfield_n_if.slave   bus
);

  localparam int unsigned LEN_W = N_BYTES * BYTE_W;
  localparam int unsigned IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAITB   = 3'd1,
    S_CLEARI  = 3'd2,
    S_INIT    = 3'd3,
    S_CHECK   = 3'd4,
    S_ISVALID = 3'd5,
    S_LOCKED  = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    length_q, length_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   hold_q, hold_d;
  logic [LEN_W-1:0]    shifted_s;
  logic [32:0]         len_ext_s;
  logic                in_range_s;
  logic                at_limit_s;

  // New byte enters at the least-significant end; a single-byte field is just the byte.
  if (N_BYTES > 1) begin : g_shift
    assign shifted_s = {length_q[LEN_W-BYTE_W-1:0], hold_q};
  end else begin : g_single
    assign shifted_s = hold_q;
  end

  // Unsigned range compare done at 33 bits so 32-bit lengths never wrap.
  assign len_ext_s  = 33'(length_q);
  assign in_range_s = (len_ext_s >= 33'(MIN_LEN)) && (len_ext_s <= 33'(MAX_LEN));
  assign at_limit_s = (cnt_q == CNT_W'(TIMEOUT_CYC));

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      length_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  // Next-state and datapath update; inputs are only honoured in their own states.
  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    case (state_q)
      S_IDLE: begin
        if (bus.VALIDSTART) begin
          state_d  = S_WAITB;
          length_d = '0;
          idx_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WAITB: begin
        if (bus.RXINT) begin
          hold_d  = bus.RXDATA;
          state_d = S_CLEARI;
        end else if ((TIMEOUT_CYC != 32'd0) && at_limit_s) begin
          state_d = S_ERROR;
        end else if (!at_limit_s) begin
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      S_CLEARI: state_d = S_INIT;
      S_INIT: begin
        length_d = shifted_s;
        if (idx_q == IDX_W'(N_BYTES - 1)) begin
          state_d = S_CHECK;
        end else begin
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
          state_d = S_WAITB;
        end
      end
      S_CHECK: begin
        if (in_range_s) begin
          state_d = S_ISVALID;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_ISVALID: state_d = S_LOCKED;
      S_LOCKED, S_ERROR: begin
        if (bus.UNLOCKME) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the state register; LENGTH comes straight from its register.
  always_comb begin
    bus.CLEARFLAG       = (state_q == S_CLEARI);
    bus.INITFLAG        = (state_q == S_INIT) ? (N_BYTES'(1) << idx_q) : '0;
    bus.VALIDLENGTHFLAG = (state_q == S_ISVALID);
    bus.ERRFLAG         = (state_q == S_ERROR);
    bus.LOCKEDFLAG      = (state_q == S_LOCKED);
    bus.UNLOCKPASTFLAG  = (state_q == S_IDLE);
    bus.LENGTH          = length_q;
  end

endmodule

// File: tb/tb_ctl_unit_lfield_n.sv
// Scoreboard bench for ctl_unit_lfield_n: a 2-byte instance and a 3-byte
// instance share one stimulus driver selected by sel3. Expected strobe events
// are queued when a frame is issued; monitors pop and compare on each event.
module tb_ctl_unit_lfield_n;

  localparam logic [1:0] K_CLR  = 2'd0;
  localparam logic [1:0] K_INIT = 2'd1;
  localparam logic [1:0] K_VAL  = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, vs, rx, um, sel3;
  logic [7:0] data;
  int         checks = 0;
  int         errors = 0;
  ev_t        q2[$];
  ev_t        q3[$];
  logic       ep2 = 1'b0;
  logic       ep3 = 1'b0;

  always #5 clk = ~clk;

  ctl_unit_lfield_n_if #(.N_BYTES(2), .BYTE_W(8)) bus2 ();
  ctl_unit_lfield_n_if #(.N_BYTES(3), .BYTE_W(8)) bus3 ();

  ctl_unit_lfield_n #(.N_BYTES(2), .BYTE_W(8), .MIN_LEN(1), .MAX_LEN(64),
                      .TIMEOUT_CYC(100)) dut2 (.clk(clk), .reset(rst), .bus(bus2));
  ctl_unit_lfield_n #(.N_BYTES(3), .BYTE_W(8), .MIN_LEN(1), .MAX_LEN(64),
                      .TIMEOUT_CYC(100)) dut3 (.clk(clk), .reset(rst), .bus(bus3));

  assign bus2.VALIDSTART = vs & ~sel3;
  assign bus3.VALIDSTART = vs & sel3;
  assign bus2.RXINT      = rx & ~sel3;
  assign bus3.RXINT      = rx & sel3;
  assign bus2.UNLOCKME   = um & ~sel3;
  assign bus3.UNLOCKME   = um & sel3;
  assign bus2.RXDATA     = data;
  assign bus3.RXDATA     = data;

  logic [31:0] len_s;
  logic        locked_s, err_s, idle_s, valid_s, clr_s;
  assign len_s    = sel3 ? 32'(bus3.LENGTH) : 32'(bus2.LENGTH);
  assign locked_s = sel3 ? bus3.LOCKEDFLAG : bus2.LOCKEDFLAG;
  assign err_s    = sel3 ? bus3.ERRFLAG : bus2.ERRFLAG;
  assign idle_s   = sel3 ? bus3.UNLOCKPASTFLAG : bus2.UNLOCKPASTFLAG;
  assign valid_s  = sel3 ? bus3.VALIDLENGTHFLAG : bus2.VALIDLENGTHFLAG;
  assign clr_s    = sel3 ? bus3.CLEARFLAG : bus2.CLEARFLAG;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    if (sel3) q3.push_back(e);
    else      q2.push_back(e);
  endtask

  task automatic mon_event(input bit is3, input logic [1:0] k, input logic [31:0] v);
    ev_t e;
    if ((is3 ? q3.size() : q2.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut%0d: got kind %0d val 0x%0h expected none at %0t",
               is3 ? 3 : 2, k, v, $time);
    end else begin
      e = is3 ? q3.pop_front() : q2.pop_front();
      chk(is3 ? "ev_kind_dut3" : "ev_kind_dut2", 32'(k), 32'(e.kind));
      chk(is3 ? "ev_val_dut3" : "ev_val_dut2", v, e.val);
    end
  endtask

  // Monitors: pop the scoreboard whenever either DUT presents a strobe or a new error.
  initial begin
    forever begin
      @(negedge clk);
      if (bus2.CLEARFLAG)         mon_event(1'b0, K_CLR, 32'd0);
      if (|bus2.INITFLAG)         mon_event(1'b0, K_INIT, 32'(bus2.INITFLAG));
      if (bus2.VALIDLENGTHFLAG)   mon_event(1'b0, K_VAL, 32'(bus2.LENGTH));
      if (bus2.ERRFLAG && !ep2)   mon_event(1'b0, K_ERR, 32'(bus2.LENGTH));
      ep2 = bus2.ERRFLAG;
      if (bus3.CLEARFLAG)         mon_event(1'b1, K_CLR, 32'd0);
      if (|bus3.INITFLAG)         mon_event(1'b1, K_INIT, 32'(bus3.INITFLAG));
      if (bus3.VALIDLENGTHFLAG)   mon_event(1'b1, K_VAL, 32'(bus3.LENGTH));
      if (bus3.ERRFLAG && !ep3)   mon_event(1'b1, K_ERR, 32'(bus3.LENGTH));
      ep3 = bus3.ERRFLAG;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic start();
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
  endtask

  // Called in a WAITB cycle t; returns at t+3.
  task automatic send(input logic [7:0] b);
    rx   = 1'b1;
    data = b;
    @(negedge clk);
    chk("clearflag_t1", 32'(clr_s), 32'd1);
    rx = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] bv, input int n, input bit ok);
    for (int k = 0; k < n; k++) begin
      push(K_CLR, 32'd0);
      push(K_INIT, 32'd1 << k);
    end
    push(ok ? K_VAL : K_ERR, bv);
    start();
    for (int k = 0; k < n; k++) send(bv[8*(n-1-k) +: 8]);
    chk("no_result_before_t4", 32'(valid_s | err_s), 32'd0);
    @(negedge clk);
    chk(ok ? "valid_t4" : "err_t4", 32'(ok ? valid_s : err_s), 32'd1);
    @(negedge clk);
    chk(ok ? "locked_level" : "err_level", 32'(ok ? locked_s : err_s), 32'd1);
    chk("length_held", len_s, bv);
  endtask

  task automatic unlock();
    um = 1'b1;
    @(negedge clk);
    um = 1'b0;
    chk("unlockpast", 32'(idle_s), 32'd1);
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; rx = 1'b0; um = 1'b0; sel3 = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle2", 32'(bus2.UNLOCKPASTFLAG), 32'd1);
    chk("rst_outs2", {26'd0, bus2.CLEARFLAG, bus2.INITFLAG, bus2.VALIDLENGTHFLAG,
                      bus2.ERRFLAG, bus2.LOCKEDFLAG}, 32'd0);
    chk("rst_len2", 32'(bus2.LENGTH), 32'd0);
    chk("rst_idle3", 32'(bus3.UNLOCKPASTFLAG), 32'd1);
    chk("rst_len3", 32'(bus3.LENGTH), 32'd0);

    // Nominal frame, then RXINT/VALIDSTART while LOCKED are ignored.
    frame(32'h0020, 2, 1'b1);
    rx = 1'b1; data = 8'hAA; vs = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b0; vs = 1'b0;
    @(negedge clk);
    chk("locked_ignores_rx", 32'(locked_s), 32'd1);
    chk("locked_len_unchanged", len_s, 32'h0020);
    unlock();

    // Out of range: 256 and 0.
    frame(32'h0100, 2, 1'b0);
    unlock();
    frame(32'h0000, 2, 1'b0);
    unlock();

    // Timeout after the first byte.
    push(K_CLR, 32'd0); push(K_INIT, 32'd1); push(K_ERR, 32'h0000);
    start();
    send(8'h00);
    repeat (100) @(negedge clk);
    chk("timeout_not_yet", 32'(err_s), 32'd0);
    @(negedge clk);
    chk("timeout_fires", 32'(err_s), 32'd1);
    unlock();

    // Byte arriving in the counter==limit cycle wins over the timeout.
    push(K_CLR, 32'd0); push(K_INIT, 32'd1);
    push(K_CLR, 32'd0); push(K_INIT, 32'd2); push(K_VAL, 32'h0030);
    start();
    send(8'h00);
    repeat (100) @(negedge clk);
    send(8'h30);
    @(negedge clk);
    chk("late_byte_valid", 32'(valid_s), 32'd1);
    @(negedge clk);
    chk("late_byte_locked", 32'(locked_s), 32'd1);
    unlock();

    // Reset in WAITB for byte 2, then a clean frame.
    push(K_CLR, 32'd0); push(K_INIT, 32'd1);
    start();
    send(8'h07);
    chk("pre_reset_len", len_s, 32'h0007);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midframe_rst_idle", 32'(idle_s), 32'd1);
    chk("midframe_rst_len", len_s, 32'd0);
    frame(32'h0005, 2, 1'b1);
    unlock();

    // UNLOCKME while in WAITB is ignored.
    push(K_CLR, 32'd0); push(K_INIT, 32'd1);
    push(K_CLR, 32'd0); push(K_INIT, 32'd2); push(K_VAL, 32'h0011);
    start();
    um = 1'b1;
    repeat (3) @(negedge clk);
    um = 1'b0;
    chk("unlock_ignored_waitb", 32'(idle_s), 32'd0);
    send(8'h00);
    send(8'h11);
    @(negedge clk);
    @(negedge clk);
    chk("after_unlockme_locked", 32'(locked_s), 32'd1);
    chk("after_unlockme_len", len_s, 32'h0011);
    unlock();

    // Three-byte instance.
    sel3 = 1'b1;
    @(negedge clk);
    frame(32'h000040, 3, 1'b1);
    unlock();
    frame(32'h000041, 3, 1'b0);
    unlock();
    sel3 = 1'b0;

    repeat (3) @(negedge clk);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
